// File: rtl/nvdla_csb_seq.sv
// nvdla_csb_seq: queues CSB register commands in a small FIFO and plays them
// out one at a time on the CSB request port. Each command can optionally wait
// for a read response and/or the NVDLA interrupt. Waits are guarded by a
// timeout that parks the sequencer in a sticky error state until cleared.
module nvdla_csb_seq #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [ADDR_W-1:0]        cmd_addr_i,
    input  logic [DATA_W-1:0]        cmd_wdata_i,
    input  logic                     cmd_write_i,
    input  logic                     cmd_wait_intr_i,
    output logic                     csb_valid_o,
    input  logic                     csb_ready_i,
    output logic [ADDR_W-1:0]        csb_addr_o,
    output logic [DATA_W-1:0]        csb_wdata_o,
    output logic                     csb_write_o,
    input  logic                     csb_rvalid_i,
    input  logic [DATA_W-1:0]        csb_rdata_i,
    input  logic                     intr_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     rdata_valid_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W + 2;
    // The counter only has to reach TIMEOUT-1: the cycle that would make it
    // TIMEOUT is the one that moves the FSM into ERROR.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_WAIT_INTR,
        S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [LVL_W-1:0]   r_level;

    logic [ADDR_W-1:0]  r_req_addr;
    logic [DATA_W-1:0]  r_req_wdata;
    logic               r_req_write;
    logic               r_req_wait;

    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_rdata_valid;
    logic               r_done;
    logic               r_timeout;

    logic               w_push;
    logic               w_pop;
    logic               w_done;
    logic               w_capture;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_to_set;
    logic               w_cnt_last;
    logic               w_fifo_nonempty;
    logic [ENT_W-1:0]   w_wr_entry;
    logic [ENT_W-1:0]   w_head;

    assign cmd_ready_o     = (r_level < LVL_W'(DEPTH));
    assign w_push          = cmd_valid_i && cmd_ready_o && !clear_i;
    assign w_fifo_nonempty = (r_level != '0);
    assign w_wr_entry      = {cmd_addr_i, cmd_wdata_i, cmd_write_i, cmd_wait_intr_i};
    assign w_head          = r_mem[r_rptr];
    assign w_cnt_last      = (TIMEOUT != 0) && (r_count == CNT_LAST);

    // Command storage; contents are only ever read while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; a soft clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_capture   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (csb_ready_i) begin
                    if (!r_req_write) begin
                        w_state_nxt = S_WAIT_RD;
                        w_cnt_clr   = 1'b1;
                    end else if (r_req_wait) begin
                        w_state_nxt = S_WAIT_INTR;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            S_WAIT_RD: begin
                if (csb_rvalid_i) begin
                    w_capture = 1'b1;
                    if (r_req_wait) begin
                        w_state_nxt = S_WAIT_INTR;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end else if (w_cnt_last) begin
                    w_state_nxt = S_ERROR;
                    w_to_set    = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_WAIT_INTR: begin
                if (intr_i) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_ERROR;
                    w_to_set    = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_ERROR: begin
                w_state_nxt = S_ERROR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (clear_i) begin
            w_state_nxt = S_IDLE;
            w_pop       = 1'b0;
            w_done      = 1'b0;
            w_capture   = 1'b0;
            w_to_set    = 1'b0;
        end
    end

    // Request registers hold the popped head stable for the whole handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_write <= 1'b0;
            r_req_wait  <= 1'b0;
        end else if (w_pop) begin
            r_req_addr  <= w_head[ENT_W-1 -: ADDR_W];
            r_req_wdata <= w_head[DATA_W+1 : 2];
            r_req_write <= w_head[1];
            r_req_wait  <= w_head[0];
        end
    end

    // Wait counter, restarted on entry to each wait state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear_i || w_cnt_clr) begin
            r_count <= '0;
        end else if (w_cnt_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Read data is held across clears; only reset zeroes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= csb_rdata_i;
        end
    end

    // Single-cycle status pulses plus the sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_rdata_valid <= w_capture;
            r_done        <= w_done;
            if (clear_i) begin
                r_timeout <= 1'b0;
            end else if (w_to_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign csb_valid_o   = (r_state == S_ISSUE);
    assign csb_addr_o    = r_req_addr;
    assign csb_wdata_o   = r_req_wdata;
    assign csb_write_o   = r_req_write;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = r_rdata_valid;
    assign done_o        = r_done;
    assign timeout_o     = r_timeout;
    assign busy_o        = w_fifo_nonempty || (r_state != S_IDLE);
    assign level_o       = r_level;

endmodule
